// File: rtl/pipelined_divider.sv
// Pipelined restoring divider (signed/unsigned) spread over LATENCY register stages with global stall.
// Define DIVIDER_DZ_FLAG_EN to add the data_dout_dz divide-by-zero flag output.
module pipelined_divider #(
  parameter int WIDTH   = 40,
  parameter int LATENCY = 45
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_diviend_valid,
  input  logic                 data_divisor_valid,
  output logic                 data_diviend_ready,
  output logic                 data_divisor_ready,
  input  logic [WIDTH-1:0]     data_diviend_bits,
  input  logic [WIDTH-1:0]     data_divisor_bits,
  input  logic                 data_signed,
  output logic                 data_dout_valid,
  input  logic                 data_dout_ready,
  output logic [2*WIDTH-1:0]   data_dout_bits
`ifdef DIVIDER_DZ_FLAG_EN
  ,
  output logic                 data_dout_dz
`endif
);

  // Each stage retires up to STEPS quotient bits; the final stage also applies sign/zero fix-up.
  localparam int STEPS = (WIDTH + LATENCY - 1) / LATENCY;

  typedef struct packed {
    logic             vld;
    logic             neg_q;
    logic             neg_r;
    logic             dz;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] dvd;
  } stage_t;

  stage_t stage_q [LATENCY];
  stage_t stage_d [LATENCY];
  stage_t front;

  logic stall;
  logic accept;
  logic dvd_neg;
  logic dvs_neg;

  assign stall              = stage_q[LATENCY-1].vld & ~data_dout_ready;
  assign data_diviend_ready = ~stall;
  assign data_divisor_ready = ~stall;
  assign accept             = data_diviend_valid & data_divisor_valid & ~stall;

  assign dvd_neg = data_signed & data_diviend_bits[WIDTH-1];
  assign dvs_neg = data_signed & data_divisor_bits[WIDTH-1];

  // Operands enter as magnitudes; quo doubles as the dividend shift register.
  always_comb begin
    front       = '0;
    front.vld   = accept;
    front.neg_q = dvd_neg ^ dvs_neg;
    front.neg_r = dvd_neg;
    front.dz    = (data_divisor_bits == '0);
    front.rem   = '0;
    front.quo   = dvd_neg ? -data_diviend_bits : data_diviend_bits;
    front.dvs   = dvs_neg ? -data_divisor_bits : data_divisor_bits;
    front.dvd   = data_diviend_bits;
  end

  function automatic stage_t div_step(input stage_t st_i);
    stage_t         st;
    logic [WIDTH:0] trial;
    st    = st_i;
    trial = {st.rem, st.quo[WIDTH-1]};
    st.quo = {st.quo[WIDTH-2:0], 1'b0};
    if (trial >= {1'b0, st.dvs}) begin
      trial     = trial - {1'b0, st.dvs};
      st.quo[0] = 1'b1;
    end
    st.rem = trial[WIDTH-1:0];
    return st;
  endfunction

  // Zero divisor overrides everything; the signed-overflow case falls out of the magnitude math.
  function automatic stage_t div_finish(input stage_t st_i);
    stage_t st;
    st = st_i;
    if (st.dz) begin
      st.quo = '1;
      st.rem = st.dvd;
    end else begin
      if (st.neg_q) st.quo = -st.quo;
      if (st.neg_r) st.rem = -st.rem;
    end
    return st;
  endfunction

  always_comb begin : p_stages
    stage_t cur;
    cur = front;
    for (int s = 0; s < LATENCY; s++) begin
      if (s > 0) cur = stage_q[s-1];
      for (int k = 0; k < STEPS; k++) begin
        if (s * STEPS + k < WIDTH) cur = div_step(cur);
      end
      if (s == LATENCY - 1) cur = div_finish(cur);
      stage_d[s] = cur;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < LATENCY; s++) stage_q[s] <= '0;
    end else if (!stall) begin
      for (int s = 0; s < LATENCY; s++) stage_q[s] <= stage_d[s];
    end
  end

  assign data_dout_valid = stage_q[LATENCY-1].vld;
  assign data_dout_bits  = {stage_q[LATENCY-1].quo, stage_q[LATENCY-1].rem};
`ifdef DIVIDER_DZ_FLAG_EN
  assign data_dout_dz    = stage_q[LATENCY-1].dz;
`endif

endmodule

// File: doc/pipelined_divider.md
PIPELINED_DIVIDER -- requirements
Module: pipelined_divider

Interface
REQ-001 Parameter WIDTH, default 40: operand width in bits (legal 2..64).
REQ-002 Parameter LATENCY, default 45: pipeline depth in cycles (legal 1..64).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data_diviend_valid  input  1  dividend operand valid.
REQ-006 data_divisor_valid  input  1  divisor operand valid.
REQ-007 data_diviend_ready  output  1  dividend accepted this cycle when high with both valids.
REQ-008 data_divisor_ready  output  1  identical to data_diviend_ready.
REQ-009 data_diviend_bits  input  WIDTH  dividend.
REQ-010 data_divisor_bits  input  WIDTH  divisor.
REQ-011 data_signed  input  1  per-operation mode, 1 = two's-complement, 0 = unsigned; sampled with operands.
REQ-012 data_dout_valid  output  1  result valid.
REQ-013 data_dout_ready  input  1  consumer accepts result.
REQ-014 data_dout_bits  output  2*WIDTH  {quotient[WIDTH-1:0], remainder[WIDTH-1:0]}, quotient in upper half.

Function
REQ-015 Accept = data_diviend_valid & data_divisor_valid & data_diviend_ready; one valid without the other SHALL not be accepted or consumed.
REQ-016 Stall = data_dout_valid & !data_dout_ready; ready outputs SHALL equal !stall (combinational).
REQ-017 On stall all LATENCY stages (data and valid) SHALL hold; otherwise all stages SHALL shift one place, stage 0 loading the accepted result with valid = accept.
REQ-018 Stall-free latency: result SHALL appear at data_dout_bits/valid exactly LATENCY cycles after the accept edge; throughput one operation per cycle.
REQ-019 Pipeline bubbles SHALL propagate as valid=0 stages; bubbles ahead of a stalled output are not collapsed.
REQ-020 Result order SHALL equal accept order; no result dropped or duplicated under any ready pattern.
REQ-021 Signed mode: quotient truncates toward zero, remainder takes sign of dividend.
REQ-022 Unsigned mode: operands treated as unsigned WIDTH-bit values.
REQ-023 Divisor zero (either mode): quotient = all ones, remainder = dividend.
REQ-024 Signed overflow (dividend = -2^(WIDTH-1), divisor = -1): quotient = dividend, remainder = 0.
REQ-025 data_dout_bits SHALL be held stable while data_dout_valid & !data_dout_ready.

Reset
REQ-026 Reset assertion SHALL immediately clear all stage valid bits and data registers; data_dout_valid = 0, data_dout_bits = 0, ready outputs = 1.
REQ-027 Reset mid-operation SHALL discard every in-flight result; first accept after deassertion yields result LATENCY cycles later.

Configuration
REQ-028 Macro DIVIDER_DZ_FLAG_EN defined: extra output data_dout_dz (1 bit, reset 0) SHALL carry, aligned with data_dout_bits, 1 when that result's divisor was zero.
REQ-029 Macro undefined: data_dout_dz port SHALL not exist; all other behaviour identical.

Verification
REQ-030 WIDTH=40, LATENCY=45, signed, 100 / -7, dout_ready=1 -> valid at cycle 45, quotient -14, remainder 2.
REQ-031 Unsigned, 0xFF_FFFF_FFFF / 2 -> quotient 0x7F_FFFF_FFFF, remainder 1.
REQ-032 Divisor 0, dividend 5 -> quotient 0xFF_FFFF_FFFF, remainder 5 (data_dout_dz=1 with macro).
REQ-033 Signed 0x80_0000_0000 / -1 -> quotient 0x80_0000_0000, remainder 0.
REQ-034 50 back-to-back ops, dout_ready toggled randomly -> 50 results in order, bits stable during stall, ready low exactly on stall cycles.
REQ-035 Reset asserted 10 cycles after 5 accepts -> dout_valid 0 immediately, no stale result after deassertion.
